// File: rtl/acq_pkg.sv
// Shared definitions for the scintillator acquisition sequencer: state encoding,
// default widths and a saturating increment.
package acq_pkg;

    localparam int unsigned TS_W_DEF  = 32;
    localparam int unsigned CNT_W_DEF = 16;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StArmed   = 3'd1,
        StWaitRd  = 3'd2,
        StReading = 3'd3,
        StClear   = 3'd4,
        StHoldoff = 3'd5
    } acq_state_e;

    // Increment holding at the all-ones value of a w-bit field (w <= 32).
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [31:0] top_val;
        top_val = (w >= 32) ? '1 : ((32'd1 << w) - 32'd1);
        return (v >= top_val) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/acq_sequencer_if.sv
// Signal bundle between the sequencer and the latch bank / SPI / MCU side.
interface acq_sequencer_if #(
    parameter int unsigned TS_W  = 32,
    parameter int unsigned CNT_W = 16
);
    logic             enable;
    logic             trigger;
    logic             spi_cs;
    logic             latch_clr_n;
    logic             irq;
    logic             armed;
    logic [TS_W-1:0]  ts_evt;
    logic [CNT_W-1:0] evt_cnt;
    logic [CNT_W-1:0] tmo_cnt;
    logic [2:0]       state_dbg;

    modport master (
        input  enable, trigger, spi_cs,
        output latch_clr_n, irq, armed, ts_evt, evt_cnt, tmo_cnt, state_dbg
    );

    modport slave (
        output enable, trigger, spi_cs,
        input  latch_clr_n, irq, armed, ts_evt, evt_cnt, tmo_cnt, state_dbg
    );
endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer with rise/fall pulses taken from the synchronized value.
module sync_edge #(
    parameter logic ResetVal = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    // [0],[1] form the synchronizer; [2] is the previous synchronized value.
    logic [2:0] sync_q, sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], d_i};
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= {3{ResetVal}};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o    = sync_q[1];
    assign rise_o = sync_q[1] & ~sync_q[2];
    assign fall_o = ~sync_q[1] & sync_q[2];
endmodule

// File: rtl/acq_sequencer.sv
// Run-control FSM for the latch bank: arm, capture, SPI readout, clear, holdoff.
// Timestamps triggers and counts normal and timed-out readouts.
module acq_sequencer
    import acq_pkg::*;
#(
    parameter int unsigned CLR_LEN    = 4,
    parameter int unsigned HOLDOFF    = 1024,
    parameter int unsigned RD_TIMEOUT = 2**20,
    parameter int unsigned TS_W       = TS_W_DEF,
    parameter int unsigned CNT_W      = CNT_W_DEF
) (
    input  logic          sys_clk_pll,
    input  logic          rst_n,
    acq_sequencer_if.master bus
);
    localparam int unsigned LimA = (CLR_LEN > HOLDOFF) ? CLR_LEN : HOLDOFF;
    localparam int unsigned Lim  = (LimA > RD_TIMEOUT) ? LimA : RD_TIMEOUT;
    localparam int unsigned TmrW = (Lim < 2) ? 1 : $clog2(Lim);
    localparam logic [TmrW-1:0] TmrMax   = TmrW'(Lim - 1);
    localparam logic [TmrW-1:0] ClrLast  = TmrW'(CLR_LEN - 1);
    localparam logic [TmrW-1:0] HoldLast = TmrW'(HOLDOFF - 1);
    localparam logic [TmrW-1:0] TmoLast  = TmrW'(RD_TIMEOUT - 1);

    acq_state_e       state_q, state_d;
    logic [TmrW-1:0]  timer_q, timer_d;
    logic [TS_W-1:0]  ts_q, ts_d;
    logic [TS_W-1:0]  ts_evt_q, ts_evt_d;
    logic [CNT_W-1:0] evt_cnt_q, evt_cnt_d;
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             latch_clr_n_q, latch_clr_n_d;

    logic enable_s, cs_rise, cs_fall;
    logic unused_en_rise, unused_en_fall, unused_cs_level;

    sync_edge #(.ResetVal(1'b0)) u_sync_enable (
        .clk_i  (sys_clk_pll),
        .rst_ni (rst_n),
        .d_i    (bus.enable),
        .q_o    (enable_s),
        .rise_o (unused_en_rise),
        .fall_o (unused_en_fall)
    );

    // Chip select idles high, so reset the synchronizer high to avoid a false edge.
    sync_edge #(.ResetVal(1'b1)) u_sync_cs (
        .clk_i  (sys_clk_pll),
        .rst_ni (rst_n),
        .d_i    (bus.spi_cs),
        .q_o    (unused_cs_level),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    always_comb begin
        state_d   = state_q;
        timer_d   = (timer_q == TmrMax) ? timer_q : timer_q + TmrW'(1);
        ts_d      = ts_q + TS_W'(1);
        ts_evt_d  = ts_evt_q;
        evt_cnt_d = evt_cnt_q;
        tmo_cnt_d = tmo_cnt_q;

        unique case (state_q)
            StIdle: begin
                if (enable_s) begin
                    state_d = StClear;
                    timer_d = '0;
                end
            end
            StArmed: begin
                if (bus.trigger) begin
                    state_d  = StWaitRd;
                    timer_d  = '0;
                    ts_evt_d = ts_q;
                end else if (!enable_s) begin
                    state_d = StIdle;
                end
            end
            StWaitRd: begin
                if (cs_fall) begin
                    state_d = StReading;
                end else if (timer_q >= TmoLast) begin
                    state_d   = StClear;
                    timer_d   = '0;
                    tmo_cnt_d = CNT_W'(sat_inc(32'(tmo_cnt_q), CNT_W));
                end
            end
            // Timer keeps running from the trigger; a chip-select release wins over expiry.
            StReading: begin
                if (cs_rise) begin
                    state_d   = StClear;
                    timer_d   = '0;
                    evt_cnt_d = CNT_W'(sat_inc(32'(evt_cnt_q), CNT_W));
                end else if (timer_q >= TmoLast) begin
                    state_d   = StClear;
                    timer_d   = '0;
                    tmo_cnt_d = CNT_W'(sat_inc(32'(tmo_cnt_q), CNT_W));
                end
            end
            StClear: begin
                if (timer_q == ClrLast) begin
                    state_d = StHoldoff;
                    timer_d = '0;
                end
            end
            StHoldoff: begin
                if (timer_q == HoldLast) begin
                    state_d = enable_s ? StArmed : StIdle;
                    timer_d = '0;
                end
            end
            default: begin
                state_d = StClear;
                timer_d = '0;
            end
        endcase

        latch_clr_n_d = (state_d != StClear);
    end

    always_ff @(posedge sys_clk_pll or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StClear;
            timer_q       <= '0;
            ts_q          <= '0;
            ts_evt_q      <= '0;
            evt_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            latch_clr_n_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            ts_q          <= ts_d;
            ts_evt_q      <= ts_evt_d;
            evt_cnt_q     <= evt_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            latch_clr_n_q <= latch_clr_n_d;
        end
    end

    assign bus.latch_clr_n = latch_clr_n_q;
    assign bus.irq         = (state_q == StWaitRd) || (state_q == StReading);
    assign bus.armed       = (state_q == StArmed);
    assign bus.ts_evt      = ts_evt_q;
    assign bus.evt_cnt     = evt_cnt_q;
    assign bus.tmo_cnt     = tmo_cnt_q;
    assign bus.state_dbg   = state_q;
endmodule
